// File: rtl/cp0_regfile_if.sv
// Port bundle between the exception unit / pipeline (master) and the CP0 register file (slave).
interface cp0_regfile_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        exc_occur;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        exc_badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] exc_pc;
    logic        int_req;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, exc_occur, exc_code, exc_epc, exc_bd,
               exc_badvaddr_we, exc_badvaddr, eret, hw_int,
        input  rd_data, status, cause, epc, exc_pc, int_req
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, exc_occur, exc_code, exc_epc, exc_bd,
               exc_badvaddr_we, exc_badvaddr, eret, hw_int,
        output rd_data, status, cause, epc, exc_pc, int_req
    );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and TI stays 0.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic         clk,
    input  logic         rst,
    cp0_regfile_if.slave bus
);
    logic [31:0] status_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic        ti;
    logic [31:0] count;
    logic [31:0] compare;
    logic        eret_go;
    logic        mtc0_go;

    // Exception wins over ERET, which wins over MTC0; losers are dropped.
    assign eret_go = bus.eret & ~bus.exc_occur;
    assign mtc0_go = bus.wr_en & ~bus.exc_occur & ~bus.eret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg   <= STATUS_RST;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
            cause_bd     <= 1'b0;
            cause_ip     <= '0;
            cause_exc    <= '0;
        end else begin
            cause_ip[7:2] <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
            if (bus.exc_occur) begin
                cause_exc <= bus.exc_code;
                if (!status_reg[1]) begin
                    epc_reg  <= bus.exc_bd ? bus.exc_epc - 32'd4 : bus.exc_epc;
                    cause_bd <= bus.exc_bd;
                end
                status_reg[1] <= 1'b1;
                if (bus.exc_badvaddr_we)
                    badvaddr_reg <= bus.exc_badvaddr;
            end else if (eret_go) begin
                status_reg[1] <= 1'b0;
            end else if (mtc0_go) begin
                case (bus.wr_addr)
                    5'd12: begin
                        status_reg[15:8] <= bus.wr_data[15:8];
                        status_reg[1:0]  <= bus.wr_data[1:0];
                    end
                    5'd13:   cause_ip[1:0] <= bus.wr_data[9:8];
                    5'd14:   epc_reg <= bus.wr_data;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick;
    logic [31:0] count_inc;
    logic        count_wr;
    logic        compare_wr;

    assign count_inc  = count + 32'd1;
    assign count_wr   = mtc0_go && (bus.wr_addr == 5'd9);
    assign compare_wr = mtc0_go && (bus.wr_addr == 5'd11);

    // Count advances on every second clock; a Count write restarts the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_wr) begin
                count <= bus.wr_data;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count_inc;
            end
            if (compare_wr) begin
                compare <= bus.wr_data;
                ti      <= 1'b0;
            end else if (!count_wr && tick && (count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_comb begin
        case (bus.rd_addr)
            5'd8:    bus.rd_data = badvaddr_reg;
            5'd9:    bus.rd_data = count;
            5'd11:   bus.rd_data = compare;
            5'd12:   bus.rd_data = status_reg;
            5'd13:   bus.rd_data = bus.cause;
            5'd14:   bus.rd_data = epc_reg;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.status  = status_reg;
    assign bus.cause   = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
    assign bus.epc     = epc_reg;
    assign bus.exc_pc  = rst ? 32'd0 : (bus.exc_occur ? EXC_VECTOR : epc_reg);
    assign bus.int_req = status_reg[0] & ~status_reg[1] & |(cause_ip & status_reg[15:8]);
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS32 pipeline. It is the receiving end of the exception unit's write bundle: it holds BadVAddr, Count, Compare, Status, Cause and EPC, and commits exception side effects atomically. It also serves MFC0/MTC0, clears EXL on ERET, latches hardware interrupts into Cause.IP and raises the pending-interrupt request back to the exception unit.

## Interface
Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0, IM=0)
- EXC_VECTOR, 32'hBFC0_0380, vector driven on exc_pc while an exception commits

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  5  MFC0 register number
- rd_data  out  32  combinational read of rd_addr (0 for unimplemented numbers)
- wr_en  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register number
- wr_data  in  32  MTC0 data
- exc_occur  in  1  exception commit this cycle
- exc_code  in  5  ExcCode to record
- exc_epc  in  32  faulting instruction PC
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badvaddr_we  in  1  load BadVAddr (address errors only)
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit this cycle
- hw_int  in  6  external interrupt lines, level-sensitive
- status  out  32  current Status
- cause  out  32  current Cause
- epc  out  32  current EPC (ERET target)
- exc_pc  out  32  EXC_VECTOR when exc_occur, else epc
- int_req  out  1  IE & !EXL & |(Cause.IP & Status.IM)

## Operation
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- Writable via MTC0: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8] only; EPC, Compare and Count all 32 bits; BadVAddr read-only. Writes to other fields or registers are ignored.
- Each cycle: Cause.IP[7:2] <= {hw_int[5] | TI, hw_int[4:0]}.
- Exception commit (exc_occur=1):
  - Cause.ExcCode <= exc_code.
  - If Status.EXL=0: EPC <= exc_bd ? exc_epc-4 : exc_epc, and Cause.BD <= exc_bd.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - BadVAddr <= exc_badvaddr when exc_badvaddr_we=1.
- ERET (eret=1, exc_occur=0): Status.EXL <= 0.
- Same-cycle priority: exception > ERET > MTC0. A losing ERET or MTC0 is dropped entirely.
- Exception to Count/Compare (timer) interaction: the exception path never writes Count or Compare.

## Timing
- All register updates land on the rising edge after the request. rd_data, status, cause, epc and int_req reflect pre-edge values, with no write bypass.
- MTC0 to Status followed by MFC0 in the next cycle returns the new value (1-cycle latency).
- int_req is combinational from registered state. A hw_int change reaches int_req 1 cycle later.
- Reset (asynchronous, may occur mid-operation) takes effect immediately:
  - Status=STATUS_RST.
  - Cause, EPC, BadVAddr, Count and Compare = 0.
  - Tick flop = 0, TI = 0.
  - int_req=0, exc_pc=0.
- Count wraps 32'hFFFF_FFFF -> 0 with no flag.

## Configuration
- CP0_TIMER_EN defined:
  - Count increments on every second clock, via a tick flop toggling each cycle.
  - An MTC0 to Count loads the value and resets the tick flop.
  - When Count == Compare after an update, Cause.TI(bit 30) <= 1.
  - An MTC0 to Compare clears TI.
  - TI is ORed into IP7.
- CP0_TIMER_EN undefined:
  - Count and Compare read 0 and writes to them are ignored.
  - TI is held at 0, and IP7 = hw_int[5] only.

## Test plan
- Reset checks:
  - Pulse rst mid-cycle -> Status=0x0040_0000, Cause=0, EPC=0 and int_req=0 immediately, without waiting for a clock edge.
  - Read of register 7 returns 0.
- Syscall commit with EXL=0: exc_code=8, exc_epc=0xBFC0_0100, exc_bd=0 -> next cycle EPC=0xBFC0_0100, Cause.ExcCode=8, Status.EXL=1; exc_pc=0xBFC0_0380 during the commit cycle.
- Delay-slot fault: exc_bd=1, exc_epc=0x8000_0010, exc_badvaddr_we=1, exc_badvaddr=0x1235 -> EPC=0x8000_000C, Cause.BD=1, BadVAddr=0x1235. A second exception while EXL=1 changes ExcCode only.
- Same-cycle conflict: exc_occur, eret and MTC0 Status=0x0000_FF01 all asserted -> EXL=1 and Status IM/IE unchanged. eret alone next cycle -> EXL=0.
- Interrupt path:
  - MTC0 Status=0x0000_0401, then hw_int=6'b000001 -> Cause.IP2=1 and int_req=1 two cycles after the write.
  - Setting EXL drops int_req to 0.
- Timer (CP0_TIMER_EN defined):
  - Count=10, Compare=12 -> TI=1 four clocks later, and IP7 is set.
  - MTC0 Compare clears TI.
  - With the macro undefined, MTC0 Count=5 reads back 0.
